// File: rtl/pcie_mem_responder.sv
// Completer for the byte-wide mem_s request bus: a 255-byte register file with a
// read-only link-generation status byte at 0xFF, plus a response FIFO toward the consumer.
module pcie_mem_responder #(
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [7:0] req_addr_i,
    input  logic [7:0] req_data_i,
    input  logic       req_wr_i,
    input  logic       req_rd_i,
    input  logic [1:0] link_gen_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_addr_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_err_o,
    output logic [7:0] err_cnt_o
);

    localparam int unsigned PTR_W       = $clog2(RESP_DEPTH);
    localparam int unsigned CNT_W       = PTR_W + 1;
    localparam int unsigned MEM_BYTES   = 255;
    localparam logic [7:0]  STATUS_ADDR = 8'hFF;
    localparam logic [7:0]  ERR_MAX     = 8'hFF;

    // Register file and response storage
    logic [7:0] mem_q      [MEM_BYTES];
    logic [7:0] fifo_addr_q[RESP_DEPTH];
    logic [7:0] fifo_data_q[RESP_DEPTH];
    logic       fifo_err_q [RESP_DEPTH];

    // Control state
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ready_q,  ready_d;
    logic             valid_q,  valid_d;
    logic [7:0]       head_addr_q, head_addr_d;
    logic [7:0]       head_data_q, head_data_d;
    logic             head_err_q,  head_err_d;
    logic [7:0]       err_cnt_q,   err_cnt_d;

    // Request decode
    logic       accept;
    logic       is_status;
    logic       wr_only;
    logic       rd_only;
    logic       wr_rd;
    logic       mem_we;
    logic       enq;
    logic       deq;
    logic       enq_err;
    logic [7:0] enq_data;
    logic [7:0] mem_rd_byte;

    always_comb begin
        accept      = req_valid_i && ready_q;
        is_status   = (req_addr_i == STATUS_ADDR);
        wr_only     = req_wr_i && !req_rd_i;
        rd_only     = !req_wr_i && req_rd_i;
        wr_rd       = req_wr_i && req_rd_i;
        mem_rd_byte = is_status ? {6'b0, link_gen_i} : mem_q[req_addr_i];

        mem_we   = accept && wr_only && !is_status;
        enq      = accept && (rd_only || wr_rd || (wr_only && is_status));
        // Every enqueued request carrying a write is an error; plain reads never are.
        enq_err  = req_wr_i;
        enq_data = enq_err ? 8'h00 : mem_rd_byte;
        deq      = valid_q && rsp_ready_i;
    end

    // FIFO pointer, occupancy and handshake next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        ready_d = (count_d < CNT_W'(RESP_DEPTH));
        valid_d = (count_d != '0);
    end

    // Head presentation: holds when empty, otherwise shows the entry at the next read pointer
    always_comb begin
        head_addr_d = head_addr_q;
        head_data_d = head_data_q;
        head_err_d  = head_err_q;

        if (count_d != '0) begin
            if (enq && (rd_ptr_d == wr_ptr_q)) begin
                head_addr_d = req_addr_i;
                head_data_d = enq_data;
                head_err_d  = enq_err;
            end else begin
                head_addr_d = fifo_addr_q[rd_ptr_d];
                head_data_d = fifo_data_q[rd_ptr_d];
                head_err_d  = fifo_err_q[rd_ptr_d];
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (enq && enq_err && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            head_addr_q <= 8'h00;
            head_data_q <= 8'h00;
            head_err_q  <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            head_addr_q <= head_addr_d;
            head_data_q <= head_data_d;
            head_err_q  <= head_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we) begin
            mem_q[req_addr_i] <= req_data_i;
        end
    end

    // Entry storage needs no reset; occupancy alone decides what is live
    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_addr_q[wr_ptr_q] <= req_addr_i;
            fifo_data_q[wr_ptr_q] <= enq_data;
            fifo_err_q[wr_ptr_q]  <= enq_err;
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = valid_q;
    assign rsp_addr_o  = head_addr_q;
    assign rsp_data_o  = head_data_q;
    assign rsp_err_o   = head_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_pcie_mem_responder.sv
// Scoreboard bench for pcie_mem_responder: a reference model queues expected responses,
// a separate monitor compares them against the response port.
module tb_pcie_mem_responder;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       req_wr;
    logic       req_rd;
    logic [1:0] link_gen;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] err_cnt;

    pcie_mem_responder #(.RESP_DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .req_data_i (req_data),
        .req_wr_i   (req_wr),
        .req_rd_i   (req_rd),
        .link_gen_i (link_gen),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_addr_o (rsp_addr),
        .rsp_data_o (rsp_data),
        .rsp_err_o  (rsp_err),
        .err_cnt_o  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    rsp_t       exp_q[$];
    rsp_t       last_head;
    logic [7:0] mem_m[256];
    int         m_cnt = 0;
    int         m_err = 0;
    bit         ready_blocked = 1'b1;
    bit         armed = 1'b0;
    bit         rand_ready = 1'b0;
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    // Reference model: decides acceptance from its own occupancy and pushes expectations
    bit   m_rdy, m_acc, m_deq, m_push;
    rsp_t m_r;
    initial begin
        forever begin
            @(negedge clk);
            m_rdy = !ready_blocked && (m_cnt < int'(DEPTH));
            if (armed) begin
                check8("req_ready", 8'(req_ready), 8'(m_rdy));
                check8("err_cnt", err_cnt, 8'(m_err));
                check8("rsp_valid_cnt", 8'(rsp_valid), 8'(m_cnt != 0));
            end
            if (!rst_n) begin
                for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
                exp_q.delete();
                m_cnt         = 0;
                m_err         = 0;
                last_head     = '{8'h00, 8'h00, 1'b0};
                ready_blocked = 1'b1;
                armed         = 1'b1;
            end else begin
                m_acc  = req_valid && m_rdy;
                m_deq  = (m_cnt > 0) && rsp_ready;
                m_push = 1'b0;
                if (m_acc) begin
                    if (req_wr && req_rd) begin
                        m_r = '{req_addr, 8'h00, 1'b1}; m_push = 1'b1;
                    end else if (req_wr) begin
                        if (req_addr == 8'hFF) begin
                            m_r = '{req_addr, 8'h00, 1'b1}; m_push = 1'b1;
                        end else begin
                            mem_m[req_addr] = req_data;
                        end
                    end else if (req_rd) begin
                        m_r = '{req_addr, (req_addr == 8'hFF) ? {6'b0, link_gen} : mem_m[req_addr], 1'b0};
                        m_push = 1'b1;
                    end
                end
                if (m_push) begin
                    exp_q.push_back(m_r);
                    if (m_r.err && m_err < 255) m_err++;
                end
                m_cnt = m_cnt + int'(m_push) - int'(m_deq);
                ready_blocked = 1'b0;
            end
        end
    end

    // Monitor: compares the presented head with the oldest expectation
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (armed) begin
                if (exp_q.size() > 0) begin
                    check8("rsp_valid", 8'(rsp_valid), 8'h01);
                    check8("rsp_addr", rsp_addr, exp_q[0].addr);
                    check8("rsp_data", rsp_data, exp_q[0].data);
                    check8("rsp_err", 8'(rsp_err), 8'(exp_q[0].err));
                    if (rsp_ready) last_head = exp_q.pop_front();
                end else begin
                    check8("rsp_valid_idle", 8'(rsp_valid), 8'h00);
                    check8("hold_addr", rsp_addr, last_head.addr);
                    check8("hold_data", rsp_data, last_head.data);
                    check8("hold_err", 8'(rsp_err), 8'(last_head.err));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) rsp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        logic got;
        req_valid = 1'b1;
        req_wr    = w;
        req_rd    = r;
        req_addr  = a;
        req_data  = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            got = req_ready;
            @(posedge clk);
            #1;
            if (got) begin
                req_valid = 1'b0;
                return;
            end
        end
        n_vec++;
        n_bad++;
        $display("FAIL accept_timeout addr %02h: got no req_ready expected acceptance within 100 cycles", a);
        req_valid = 1'b0;
    endtask

    int cls;
    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_rd = 1'b0;
        req_addr = 8'h00; req_data = 8'h00; link_gen = 2'b00; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Write then read-after-write, plus an untouched address
        send(1'b1, 1'b0, 8'h10, 8'hA5);
        send(1'b0, 1'b1, 8'h10, 8'h00);
        send(1'b0, 1'b1, 8'h11, 8'h00);
        idle(3);

        // Fill with consumer stalled, fifth request waits for one dequeue
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 8'(8'h10 + i), 8'h00);
        req_valid = 1'b1; req_wr = 1'b0; req_rd = 1'b1; req_addr = 8'h14;
        idle(3);
        rsp_ready = 1'b1;
        idle(1);
        rsp_ready = 1'b0;
        send(1'b0, 1'b1, 8'h14, 8'h00);
        idle(2);
        rsp_ready = 1'b1;
        idle(8);

        // Status byte reads and a dropped write to it
        link_gen = 2'b01;
        send(1'b0, 1'b1, 8'hFF, 8'h00);
        send(1'b1, 1'b0, 8'hFF, 8'h55);
        send(1'b0, 1'b1, 8'hFF, 8'h00);
        link_gen = 2'b11;
        send(1'b0, 1'b1, 8'hFF, 8'h00);
        idle(4);

        // Conflicting and empty commands
        send(1'b1, 1'b1, 8'h20, 8'h77);
        send(1'b0, 1'b1, 8'h20, 8'h00);
        send(1'b0, 1'b0, 8'h30, 8'h12);
        idle(4);

        // Reset with responses pending
        send(1'b1, 1'b0, 8'h40, 8'h99);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 8'h40, 8'h00);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        send(1'b0, 1'b1, 8'h40, 8'h00);
        send(1'b0, 1'b1, 8'h10, 8'h00);
        idle(4);

        // Randomized mix with a stalling consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cls = int'($urandom_range(0, 3));
            link_gen = 2'($urandom);
            send(cls == 0 || cls == 2, cls == 1 || cls == 2,
                 ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 15)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        rand_ready = 1'b0;
        rsp_ready = 1'b1;
        idle(10);

        // Error flood drives the counter to saturation and wraps the pointers many times
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) send(1'b1, 1'b1, 8'($urandom), 8'($urandom));
            else            send(1'b1, 1'b0, 8'hFF, 8'($urandom));
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish before 2ms");
        $fatal(1);
    end

endmodule
